// File: rtl/fadd_issue_ctrl.sv
// fadd_issue_ctrl: issue/response controller for a fixed-latency pipelined FP32 adder core.
// Tracks in-flight ops in a latency-matched pipe and returns results in order through a
// credit-protected FIFO. Optional feature macro: FADD_SPECIAL_BYPASS_EN (special-operand bypass).
module fadd_issue_ctrl #(
   parameter int LAT        = 3,
   parameter int TAG_W      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic             req_sub,
   input  logic [TAG_W-1:0] req_tag,
   output logic [31:0]      core_a,
   output logic [31:0]      core_b,
   input  logic [31:0]      core_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_y,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_byp
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W:0]   CREDIT   = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             byp;
      logic [31:0]      y;
   } slot_t;

   logic [31:0]      b_adj;
   logic             byp;
   logic [31:0]      byp_y;
   logic             accept;
   logic             push;
   logic             pop;
   slot_t            push_slot;
   logic [LAT-1:0]   pipe_valid;
   slot_t            pipe_slot [LAT];
   slot_t            fifo_mem  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] fifo_count;

   // Operands go to the core unconditionally; only accepted slots ever use the result.
   assign b_adj  = {req_b[31] ^ req_sub, req_b[30:0]};
   assign core_a = req_a;
   assign core_b = b_adj;

   // Credit covers every op that will eventually occupy a FIFO entry, so a push never finds it full.
   assign req_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < CREDIT;
   assign accept    = req_valid & req_ready;
   assign push      = pipe_valid[LAT-1];
   assign pop       = rsp_valid & rsp_ready;

`ifdef FADD_SPECIAL_BYPASS_EN
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_diff;

   assign a_zero    = (req_a[30:23] == 8'h00);
   assign b_zero    = (b_adj[30:23] == 8'h00);
   assign a_inf     = (req_a[30:23] == 8'hFF) && (req_a[22:0] == 23'h0);
   assign b_inf     = (b_adj[30:23] == 8'hFF) && (b_adj[22:0] == 23'h0);
   assign a_nan     = (req_a[30:23] == 8'hFF) && (req_a[22:0] != 23'h0);
   assign b_nan     = (b_adj[30:23] == 8'hFF) && (b_adj[22:0] != 23'h0);
   assign sign_diff = req_a[31] ^ b_adj[31];

   // Special-operand classification; first matching rule wins, denormals count as zero.
   // NOTE: both outputs get a default first, so no path through the if-chain can infer a latch.
   always_comb begin
      byp   = 1'b1;
      byp_y = 32'h0000_0000;
      if (a_nan || b_nan || (a_inf && b_inf && sign_diff)) byp_y = 32'h7FC0_0000;
      else if (a_inf)                                       byp_y = req_a;
      else if (b_inf)                                       byp_y = b_adj;
      else if (a_zero && b_zero)                            byp_y = {req_a[31] & b_adj[31], 31'b0};
      else if (a_zero)                                      byp_y = b_adj;
      else if (b_zero)                                      byp_y = req_a;
      else if ((req_a[30:0] == b_adj[30:0]) && sign_diff)   byp_y = 32'h0000_0000;
      else                                                  byp   = 1'b0;
   end
`else
   assign byp   = 1'b0;
   assign byp_y = 32'h0000_0000;
`endif

   // Slot-valid shift pipe, matched to the core latency; advances every cycle.
   // NOTE: non-blocking assignments make every stage sample its neighbour's pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_valid <= '0;
      end else begin
         pipe_valid[0] <= accept;
         for (int i = 1; i < LAT; i++) pipe_valid[i] <= pipe_valid[i-1];
      end
   end

   // Pipe payload is only meaningful where pipe_valid is set, so it carries no reset.
   always_ff @(posedge clk) begin
      pipe_slot[0] <= '{tag: req_tag, byp: byp, y: byp_y};
      for (int i = 1; i < LAT; i++) pipe_slot[i] <= pipe_slot[i-1];
   end

   // The last pipe stage lines up with core_y for the same op.
   always_comb begin
      push_slot     = pipe_slot[LAT-1];
      push_slot.y   = pipe_slot[LAT-1].byp ? pipe_slot[LAT-1].y : core_y;
   end

   // Outstanding-op and FIFO occupancy counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight   <= '0;
         fifo_count <= '0;
      end else begin
         case ({accept, push})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: ;
         endcase
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Response FIFO storage and pointers; the head entry drives rsp_* directly from registers.
   // NOTE: the storage is reset so rsp_y/rsp_tag/rsp_byp read zero out of reset, not X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= push_slot;
            wr_ptr           <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
   end

   assign rsp_valid = (fifo_count != '0);
   assign rsp_y     = fifo_mem[rd_ptr].y;
   assign rsp_tag   = fifo_mem[rd_ptr].tag;
   assign rsp_byp   = fifo_mem[rd_ptr].byp;

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// tb_fadd_issue_ctrl: self-checking bench for fadd_issue_ctrl with a stand-in LAT-cycle core,
// a directed vector table, backpressure and reset sequences, and a randomized scoreboard run.
module tb_fadd_issue_ctrl;
   localparam int LAT   = 3;
   localparam int TAG_W = 4;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_a;
   logic [31:0]      req_b;
   logic             req_sub;
   logic [TAG_W-1:0] req_tag;
   logic [31:0]      core_a;
   logic [31:0]      core_b;
   logic [31:0]      core_y;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_y;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_byp;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   fadd_issue_ctrl #(.LAT(LAT), .TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_tag(req_tag),
      .core_a(core_a), .core_b(core_b), .core_y(core_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_tag(rsp_tag), .rsp_byp(rsp_byp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Stand-in for the adder core: the controller never inspects the arithmetic, so any
   // deterministic function of the operands will do; the one real sum the tests name is exact.
   function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return {a[15:0], b[31:16]} ^ 32'hA5A5_0F0F;
   endfunction

   logic [31:0] core_pipe [LAT];
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
      core_pipe[0] <= core_fn(core_a, core_b);
   end
   assign core_y = core_pipe[LAT-1];

   // ---------------- reference model ----------------
   typedef enum {K_ZERO, K_INF, K_NAN, K_FIN} kind_e;
   typedef struct {
      logic [31:0]      y;
      logic [TAG_W-1:0] tag;
      logic             byp;
      int               avail;
   } exp_t;

   exp_t exp_q[$];

   function automatic kind_e kind_of(input logic [31:0] x);
      if (x[30:23] == 8'h00) return K_ZERO;
      if (x[30:23] == 8'hFF) return (x[22:0] == 23'h0) ? K_INF : K_NAN;
      return K_FIN;
   endfunction

   function automatic exp_t ref_result(input logic [31:0] a, input logic [31:0] b,
                                       input logic sub, input logic [TAG_W-1:0] tag);
      exp_t  r;
      logic [31:0] bq;
      bq     = {b[31] ^ sub, b[30:0]};
      r.tag  = tag;
      r.avail = 0;
      r.byp  = 1'b0;
      r.y    = core_fn(a, bq);
`ifdef FADD_SPECIAL_BYPASS_EN
      begin
         kind_e ka, kb;
         logic  sdiff;
         ka    = kind_of(a);
         kb    = kind_of(bq);
         sdiff = (a[31] != bq[31]);
         r.byp = 1'b1;
         if (ka == K_NAN || kb == K_NAN)           r.y = 32'h7FC0_0000;
         else if (ka == K_INF && kb == K_INF)      r.y = sdiff ? 32'h7FC0_0000 : a;
         else if (ka == K_INF)                     r.y = a;
         else if (kb == K_INF)                     r.y = bq;
         else if (ka == K_ZERO && kb == K_ZERO)    r.y = (a[31] && bq[31]) ? 32'h8000_0000 : 32'h0;
         else if (ka == K_ZERO)                    r.y = bq;
         else if (kb == K_ZERO)                    r.y = a;
         else if (a[30:0] == bq[30:0] && sdiff)    r.y = 32'h0;
         else                                      r.byp = 1'b0;
      end
`endif
      return r;
   endfunction

   // Scoreboard: an op accepted in cycle t must be visible from cycle t+LAT+1, results in order.
   always @(negedge clk) begin
      logic ev;
      exp_t h;
      if (rst) exp_q.delete();
      check("mon_req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
      ev = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      check("mon_rsp_valid", 32'(rsp_valid), 32'(ev));
      if (!rst && rsp_valid && rsp_ready && exp_q.size() > 0) begin
         h = exp_q.pop_front();
         check("mon_rsp_y",   rsp_y,          h.y);
         check("mon_rsp_tag", 32'(rsp_tag),   32'(h.tag));
         check("mon_rsp_byp", 32'(rsp_byp),   32'(h.byp));
      end
      if (!rst && req_valid && req_ready) begin
         h       = ref_result(req_a, req_b, req_sub, req_tag);
         h.avail = cyc + LAT + 1;
         exp_q.push_back(h);
      end
   end

   // ---------------- stimulus helpers ----------------
   typedef struct {
      logic [31:0]      a;
      logic [31:0]      b;
      logic             sub;
      logic [TAG_W-1:0] tag;
      logic [31:0]      y;
      logic             byp;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input logic [TAG_W-1:0] tag, input logic [31:0] y, input logic byp);
      vec_t v;
      v.a = a; v.b = b; v.sub = sub; v.tag = tag;
`ifdef FADD_SPECIAL_BYPASS_EN
      v.y = y; v.byp = byp;
`else
      v.y   = byp ? core_fn(a, {b[31] ^ sub, b[30:0]}) : y;
      v.byp = 1'b0;
`endif
      return v;
   endfunction

   function automatic logic [31:0] rnd_op();
      logic        s;
      logic [31:0] r;
      s = 1'($urandom_range(0, 1));
      r = $urandom;
      case ($urandom_range(0, 7))
         0:       return {s, 31'h0};
         1:       return {s, 8'hFF, 23'h0};
         2:       return {s, 8'hFF, r[22:0] | 23'h1};
         3:       return {s, 8'h00, r[22:0]};
         default: return r;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request and holds it until the controller takes it (bounded).
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [TAG_W-1:0] tag);
      int w;
      step();
      req_valid = 1'b1; req_a = a; req_b = b; req_sub = sub; req_tag = tag;
      w = 0;
      @(negedge clk);
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("send_accept", 32'(req_ready), 32'd1);
   endtask

   task automatic collect(input int n, input int first_tag);
      int got, waited;
      got = 0; waited = 0;
      while (got < n && waited < 60) begin
         @(negedge clk);
         waited++;
         if (rsp_valid && rsp_ready) begin
            check("bp_tag_order", 32'(rsp_tag), 32'(first_tag + got));
            got++;
         end
      end
      check("bp_rsp_count", 32'(got), 32'(n));
   endtask

   vec_t tv [12];

   initial begin
      int lat, n_acc, w;
      for (int i = 0; i < LAT; i++) core_pipe[i] = 32'h0;
      rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; req_tag = '0;
      rsp_ready = 1'b0;

      tv[0]  = mk(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5,  32'h4040_0000, 1'b0);
      tv[1]  = mk(32'h4040_0000, 32'h4040_0000, 1'b1, 4'd1,  32'h0000_0000, 1'b1);
      tv[2]  = mk(32'h0000_0000, 32'hC020_0000, 1'b0, 4'd2,  32'hC020_0000, 1'b1);
      tv[3]  = mk(32'h7F80_0000, 32'hFF80_0000, 1'b0, 4'd3,  32'h7FC0_0000, 1'b1);
      tv[4]  = mk(32'h7F80_0000, 32'h3F80_0000, 1'b0, 4'd4,  32'h7F80_0000, 1'b1);
      tv[5]  = mk(32'h7FC0_0001, 32'h1234_5678, 1'b0, 4'd6,  32'h7FC0_0000, 1'b1);
      tv[6]  = mk(32'h3F80_0000, 32'h0000_0000, 1'b1, 4'd7,  32'h3F80_0000, 1'b1);
      tv[7]  = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd8,  32'h8000_0000, 1'b1);
      tv[8]  = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 4'd9,  32'h0000_0000, 1'b1);
      tv[9]  = mk(32'h0040_0000, 32'h3F80_0000, 1'b0, 4'd10, 32'h3F80_0000, 1'b1);
      tv[10] = mk(32'hFF80_0000, 32'hFF80_0000, 1'b1, 4'd11, 32'h7FC0_0000, 1'b1);
      tv[11] = mk(32'h3F80_0000, 32'h7F80_0000, 1'b1, 4'd12, 32'hFF80_0000, 1'b1);

      // Reset state and idle behaviour.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_y",     rsp_y,          32'h0);
      check("rst_rsp_tag",   32'(rsp_tag),   32'd0);
      check("rst_rsp_byp",   32'(rsp_byp),   32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Directed vectors, one at a time, checking latency and result.
      step();
      rsp_ready = 1'b1;
      foreach (tv[i]) begin
         send(tv[i].a, tv[i].b, tv[i].sub, tv[i].tag);
         step();
         req_valid = 1'b0;
         lat = 1;
         @(negedge clk);
         while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("tv_latency", 32'(lat),      32'd4);
         check("tv_rsp_y",   rsp_y,         tv[i].y);
         check("tv_rsp_tag", 32'(rsp_tag),  32'(tv[i].tag));
         check("tv_rsp_byp", 32'(rsp_byp),  32'(tv[i].byp));
      end

      // Backpressure: credit limits acceptance to DEPTH, results drain in order.
      step();
      rsp_ready = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         req_valid = 1'b1; req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_sub = 1'b0;
         req_tag = TAG_W'(i);
         @(negedge clk);
         if (req_ready) n_acc++;
      end
      step();
      req_valid = 1'b0;
      @(negedge clk);
      check("bp_accepted",  32'(n_acc),     32'd8);
      check("bp_ready_low", 32'(req_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_tag",   32'(rsp_tag),   32'd0);
         check("bp_hold_y",     rsp_y,          32'h4040_0000);
      end
      step();
      rsp_ready = 1'b1;
      collect(8, 0);
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd8);
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd9);
      step();
      req_valid = 1'b0;
      collect(2, 8);

      // Reset with two ops in flight: nothing from before the reset may come out.
      send(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd3);
      send(32'h4040_0000, 32'h3F80_0000, 1'b0, 4'd4);
      step();
      req_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
         check("rst_mid_ready",  32'(req_ready), 32'd1);
      end

      // Randomized traffic with random backpressure, checked by the scoreboard.
      for (int c = 0; c < 400; c++) begin
         step();
         req_valid = ($urandom_range(0, 3) != 0);
         req_a     = rnd_op();
         req_b     = ($urandom_range(0, 5) == 0) ? req_a : rnd_op();
         req_sub   = 1'($urandom_range(0, 1));
         req_tag   = TAG_W'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      check("drain_empty",     32'(exp_q.size()), 32'd0);
      check("drain_rsp_valid", 32'(rsp_valid),    32'd0);
      check("drain_req_ready", 32'(req_ready),    32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fadd_issue_ctrl.md
# fadd_issue_ctrl

Issue/response controller for the three-stage pipelined single-precision adder core. Accepts tagged add/sub requests over a valid/ready handshake and drives the core's operand inputs. Tracks in-flight operations in a latency-matched shift pipe, resolves IEEE special operands the core cannot handle, and returns results in issue order through a credit-protected output FIFO that tolerates downstream backpressure.

## Interface
- LAT, 3, cycles from core_a/core_b presented to core_y valid; fixed, the core never stalls
- TAG_W, 4, request/response tag width
- FIFO_DEPTH, 8, output FIFO entries; also the total outstanding-operation credit
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept this cycle
- req_a  in  32  operand A (IEEE-754 single)
- req_b  in  32  operand B
- req_sub  in  1  1 = A − B (B sign inverted before use)
- req_tag  in  TAG_W  opaque tag returned with result
- core_a  out  32  core operand A
- core_b  out  32  core operand B (sign already adjusted)
- core_y  in  32  core result, LAT cycles after operands
- rsp_valid  out  1  result available (FIFO head)
- rsp_ready  in  1  consumer accepts result
- rsp_y  out  32  result
- rsp_tag  out  TAG_W  tag of result
- rsp_byp  out  1  result produced by special-case bypass, not the core

## Operation
- Accept = req_valid & req_ready. req_ready = (inflight + fifo_count) < FIFO_DEPTH; derived from registers only, with no combinational path from rsp_ready.
- b' = {req_b[31]^req_sub, req_b[30:0]}. core_a = req_a and core_b = b' continuously, combinationally. The core output is used only for accepted slots.
- On accept: shift pipe stage 0 captures {valid=1, tag, byp, byp_y}. Otherwise stage 0 captures valid=0. The pipe advances every cycle.
- At pipe stage LAT−1 with valid=1: push {byp ? byp_y : core_y, tag, byp} into the FIFO. The credit rule guarantees the FIFO is never full on push.
- inflight: +1 on accept, −1 on push, both in the same cycle → unchanged. fifo_count: +1 on push, −1 on pop (rsp_valid & rsp_ready).
- Bypass classification is on req_a and b'. Exponent 0 counts as zero (denormals flush to signed zero). First matching rule wins:
  - either operand NaN, or Inf + opposite-sign Inf → 7FC00000
  - either operand Inf → that Inf
  - both zero → {a_s & b'_s, 31'b0}
  - A zero → b'; B zero → A
  - A[30:0]==b'[30:0] and signs differ → 00000000
  - otherwise byp=0; the core result is used
- Results leave in issue order. No reordering, no drops.

## Timing
- Accept in cycle t → push at end of cycle t+LAT−1+1 (core_y sampled in cycle t+LAT) → rsp_valid high in cycle t+LAT+1. Request-to-response latency is LAT+1 = 4 cycles.
- Full throughput (one request per cycle, rsp_ready held high) requires FIFO_DEPTH ≥ LAT+2. The default of 8 satisfies this.
- rsp_* are registered FIFO head outputs and hold stable while rsp_valid & !rsp_ready.
- Push and pop in the same cycle with fifo_count==0: the pushed entry appears next cycle. No bypass of the FIFO register.
- Reset values: rsp_valid=0, rsp_y=0, rsp_tag=0, rsp_byp=0, all pipe valids 0, inflight=0, fifo_count=0, FIFO pointers 0. req_ready=1 immediately after reset.
- Reset mid-operation discards all in-flight and buffered results. No rsp_valid from pre-reset requests.

## Configuration
- FADD_SPECIAL_BYPASS_EN defined: classification and bypass as above. rsp_byp reflects the selected path.
- Not defined: every request goes to the core, rsp_y = core_y, rsp_byp tied 0, and the classification logic is absent. Zero, Inf, NaN and exact-cancellation results are then only as good as the core.

## Test plan
- Reset → rsp_valid=0, req_ready=1, rsp_y=00000000; no response for 20 cycles with req_valid=0.
- req_a=3F800000, req_b=40000000, sub=0, tag=5 → rsp_y=40400000, rsp_tag=5, rsp_byp=0, rsp_valid exactly 4 cycles after accept.
- 40400000 − 40400000 (sub=1) → 00000000, byp=1. 00000000 + C0200000 → C0200000, byp=1 (bypass build).
- 7F800000 + FF800000 → 7FC00000. 7F800000 + 3F800000 → 7F800000. 7FC00001 + anything → 7FC00000.
- rsp_ready=0, 10 back-to-back requests with tags 0–9 → exactly 8 accepted, req_ready low thereafter. Raise rsp_ready → 8 responses with tags 0–7 in order, then tags 8–9 accepted and returned.
- Two requests in flight, pulse rst for 1 cycle → no rsp_valid afterwards, req_ready=1, counters 0.
